bus_arbiter_rr: RTL and testbench
=================================

// Module: bus_arbiter_rr
// PURPOSE
//  N-master to single simple-bus adapter/arbiter. Successor of the 2-source core bus bridge.
//  Arbitrates I-fetch, data and extra masters (e.g. DMA, debug) onto one bus; fixed or round-robin priority.
//  All bus outputs registered; a per-transaction ack timeout reports an error to the master.
//  Sits between core/peripheral masters and the memory/peripheral bus.
// PARAMETERS
//  N_MASTERS   2    number of requesting masters (>=1); index 0 = highest fixed priority
//  XLEN        32   address/data width
//  RR_MODE     1    0 = fixed priority (lowest index wins), 1 = round-robin
//  TIMEOUT     255  BUSY cycles without i_ack before abort; 0 disables timeout
// PORTS
//  i_clk      in   1              clock
//  i_rst      in   1              synchronous reset, active-high
//  i_req      in   N_MASTERS      per-master request; held until o_ready of that master
//  i_wr       in   N_MASTERS      per-master 1=write, 0=read
//  i_addr     in   N_MASTERS*XLEN per-master address, master m at [m*XLEN +: XLEN]
//  i_wdata    in   N_MASTERS*XLEN per-master write data
//  i_size     in   N_MASTERS*3    per-master funct3 size code
//  o_ready    out  N_MASTERS      one-cycle completion pulse, one-hot
//  o_err      out  N_MASTERS      one-cycle timeout-error pulse, coincident with o_ready
//  o_rdata    out  XLEN           read data, valid while any o_ready is high
//  i_ack      in   1              bus acknowledge
//  i_rd_data  in   XLEN           bus read data, sampled on i_ack
//  o_bus_en   out  1              bus transaction active
//  o_wr_rd    out  1              1=write, 0=read
//  o_wr_data  out  XLEN           bus write data
//  o_addr     out  XLEN           bus address
//  o_size     out  3              bus size code
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; rr pointer=N_MASTERS-1 (master 0 wins first); timeout cnt=0.
//  Reset mid-transaction: transaction abandoned, no o_ready/o_err, o_bus_en low after the reset edge.
//  FSM IDLE->BUSY->RESP->IDLE.
//  IDLE: if |i_req, pick grant g; register addr/wdata/size/wr of g into bus outputs, o_bus_en<=1,
//   cnt<=0, go BUSY. No req: stay, o_bus_en=0.
//  Arbitration: RR_MODE=0 lowest set index. RR_MODE=1 first set index searching from ptr+1
//   upward with wrap at N_MASTERS-1->0; ptr<=g on grant.
//  BUSY: bus outputs stable. i_ack=1: capture i_rd_data (0 for writes), o_bus_en<=0, go RESP.
//   Else cnt++; TIMEOUT!=0 and cnt==TIMEOUT-1: o_bus_en<=0, o_rdata<=0, flag err, go RESP.
//  RESP (1 cycle): o_ready[g]=1, o_err[g]=err flag, o_rdata valid; next state IDLE.
//  Master may drop or change req/payload at the edge ending RESP; next IDLE cycle sees new value.
//  Latency: req seen in IDLE cycle 0 -> o_bus_en cycle 1 -> ack cycle k>=1 -> o_ready cycle k+1.
//   Minimum 3 cycles per transaction; back-to-back grant every 3 cycles.
//  i_req of g dropped in BUSY: illegal; transaction still completes and pulses o_ready[g].
//  i_ack in IDLE or RESP: ignored. Payload of non-granted masters never sampled.
//  N_MASTERS=1: arbitration trivial, g always 0.
// TESTING
//  T1 single read: m0 req rd addr=0x100, ack 2 cyc later, rd_data=0xDEADBEEF -> o_ready[0] 1 cyc, o_rdata=0xDEADBEEF
//  T2 write: m1 wr addr=0x200 wdata=0x12345678 size=2 -> bus shows exact values while o_bus_en; o_ready[1] after ack
//  T3 RR: m0,m1 req continuously, RR_MODE=1 -> grants alternate 0,1,0,1; RR_MODE=0 -> m0 only while it requests
//  T4 timeout: TIMEOUT=4, never ack -> o_bus_en high 4 cyc, then o_ready[g]=o_err[g]=1, o_rdata=0
//  T5 reset in BUSY: assert i_rst mid-transaction -> o_bus_en=0 next cyc, no o_ready; m0 granted first after reset
//  T6 stray ack in IDLE with no req -> no state change, all outputs remain 0

Source files
------------

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr
//   Arbitrates N masters (instruction fetch, data, DMA, debug, ...) onto one
//   simple request/acknowledge bus. Arbitration is either fixed priority
//   (lowest index wins) or round-robin. All bus-side outputs are registered.
//   A per-transaction acknowledge timeout completes the transaction with an
//   error pulse to the requesting master.
//
//   Handshake: a master raises i_req[m] with its payload and holds both until
//   it sees o_ready[m]. o_ready is a one-cycle, one-hot pulse. o_err pulses
//   together with o_ready when the bus never acknowledged. o_rdata is valid
//   while any o_ready bit is high. On the bus side, o_bus_en stays high with
//   stable address/data/size/direction until the cycle in which i_ack is seen.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_req, i_wr           per-master request and write flag
//   i_addr, i_wdata       per-master address / write data, master m at [m*XLEN +: XLEN]
//   i_size                per-master size code, master m at [m*3 +: 3]
//   o_ready, o_err        per-master completion / timeout-error pulse
//   o_rdata               read data returned to the master
//   i_ack, i_rd_data      bus acknowledge and bus read data
//   o_bus_en, o_wr_rd     bus transaction active, bus direction (1 = write)
//   o_wr_data, o_addr     bus write data and address
//   o_size                bus size code
//   dbg_state             current FSM state (0 = IDLE, 1 = BUSY, 2 = RESP)
module bus_arbiter_rr #(
    parameter int N_MASTERS = 2,
    parameter int XLEN      = 32,
    parameter int RR_MODE   = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_MASTERS-1:0]      i_req,
    input  logic [N_MASTERS-1:0]      i_wr,
    input  logic [N_MASTERS*XLEN-1:0] i_addr,
    input  logic [N_MASTERS*XLEN-1:0] i_wdata,
    input  logic [N_MASTERS*3-1:0]    i_size,
    output logic [N_MASTERS-1:0]      o_ready,
    output logic [N_MASTERS-1:0]      o_err,
    output logic [XLEN-1:0]           o_rdata,
    input  logic                      i_ack,
    input  logic [XLEN-1:0]           i_rd_data,
    output logic                      o_bus_en,
    output logic                      o_wr_rd,
    output logic [XLEN-1:0]           o_wr_data,
    output logic [XLEN-1:0]           o_addr,
    output logic [2:0]                o_size,
    output logic [1:0]                dbg_state
);

    localparam int PTR_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [PTR_W-1:0]   ptr;        // last granted master (round-robin)
    logic [PTR_W-1:0]   gnt;        // master owning the current transaction
    logic [PTR_W-1:0]   pick;
    logic               pick_vld;
    logic [CNT_W-1:0]   cnt;
    logic               err;
    logic               timeout_hit;

    // Grant selection. Round-robin starts the search one past the last
    // grant so the most recently served master has the lowest priority.
    always_comb begin
        int idx;
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (RR_MODE != 0) idx = (int'(ptr) + 1 + i) % N_MASTERS;
            else              idx = i;
            if (!pick_vld && i_req[idx]) begin
                pick     = PTR_W'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    // cnt counts completed BUSY cycles without acknowledge, so the abort
    // lands after exactly TIMEOUT cycles of o_bus_en.
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pick_vld) state_nx = BUSY;
            BUSY:    if (i_ack || timeout_hit) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr       <= PTR_W'(N_MASTERS - 1);
            gnt       <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            o_rdata   <= '0;
            o_bus_en  <= 1'b0;
            o_wr_rd   <= 1'b0;
            o_wr_data <= '0;
            o_addr    <= '0;
            o_size    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        gnt       <= pick;
                        ptr       <= pick;
                        o_addr    <= i_addr[int'(pick)*XLEN +: XLEN];
                        o_wr_data <= i_wdata[int'(pick)*XLEN +: XLEN];
                        o_size    <= i_size[int'(pick)*3 +: 3];
                        o_wr_rd   <= i_wr[pick];
                        o_bus_en  <= 1'b1;
                        cnt       <= '0;
                        err       <= 1'b0;
                    end
                end
                BUSY: begin
                    if (i_ack) begin
                        o_rdata  <= o_wr_rd ? '0 : i_rd_data;
                        o_bus_en <= 1'b0;
                        err      <= 1'b0;
                    end else if (timeout_hit) begin
                        o_rdata  <= '0;
                        o_bus_en <= 1'b0;
                        err      <= 1'b1;
                    end else if (TIMEOUT != 0) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Response pulses decode straight from registered state and grant.
    always_comb begin
        for (int m = 0; m < N_MASTERS; m++) begin
            o_ready[m] = (state == RESP) && (int'(gnt) == m);
            o_err[m]   = (state == RESP) && (int'(gnt) == m) && err;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr. A round-robin and a fixed-priority
// instance share all inputs; both use a 4-cycle acknowledge timeout.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_bus_arbiter_rr;

  localparam int N    = 2;
  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    wr;
  logic [N*XLEN-1:0] addr;
  logic [N*XLEN-1:0] wdata;
  logic [N*3-1:0]  size;
  logic            ack;
  logic [XLEN-1:0] rd_data;

  logic [N-1:0]    ready_rr, err_rr, ready_fx, err_fx;
  logic [XLEN-1:0] rdata_rr, rdata_fx, wr_data_rr, wr_data_fx, addr_rr, addr_fx;
  logic            bus_en_rr, bus_en_fx, wr_rd_rr, wr_rd_fx;
  logic [2:0]      size_rr, size_fx;
  logic [1:0]      state_rr, state_fx;

  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];
  logic [0:0] g;

  bus_arbiter_rr #(.N_MASTERS(N), .XLEN(XLEN), .RR_MODE(1), .TIMEOUT(4)) u_rr (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_wr(wr), .i_addr(addr),
    .i_wdata(wdata), .i_size(size), .o_ready(ready_rr), .o_err(err_rr),
    .o_rdata(rdata_rr), .i_ack(ack), .i_rd_data(rd_data), .o_bus_en(bus_en_rr),
    .o_wr_rd(wr_rd_rr), .o_wr_data(wr_data_rr), .o_addr(addr_rr),
    .o_size(size_rr), .dbg_state(state_rr)
  );

  bus_arbiter_rr #(.N_MASTERS(N), .XLEN(XLEN), .RR_MODE(0), .TIMEOUT(4)) u_fx (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_wr(wr), .i_addr(addr),
    .i_wdata(wdata), .i_size(size), .o_ready(ready_fx), .o_err(err_fx),
    .o_rdata(rdata_fx), .i_ack(ack), .i_rd_data(rd_data), .o_bus_en(bus_en_fx),
    .o_wr_rd(wr_rd_fx), .o_wr_data(wr_data_fx), .o_addr(addr_fx),
    .o_size(size_fx), .dbg_state(state_fx)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; wr = '0; addr = '0; wdata = '0; size = '0;
    ack = 1'b0; rd_data = '0;
    step(); step();
    check("rst_bus_en", 32'(bus_en_rr), 32'd0);
    check("rst_ready", 32'(ready_rr), 32'd0);
    check("rst_err", 32'(err_rr), 32'd0);
    check("rst_rdata", rdata_rr, 32'd0);
    check("rst_addr", addr_rr, 32'd0);
    check("rst_state", 32'(state_rr), 32'd0);
    rst = 1'b0;

    // T6: stray acknowledge while idle
    ack = 1'b1; rd_data = 32'hFFFF_FFFF;
    step();
    check("t6_state", 32'(state_rr), 32'd0);
    check("t6_bus_en", 32'(bus_en_rr), 32'd0);
    check("t6_ready", 32'(ready_rr), 32'd0);
    check("t6_rdata", rdata_rr, 32'd0);
    check("t6_wr_data", wr_data_rr, 32'd0);
    ack = 1'b0;
    step();

    // T1: single read from master 0, acknowledged in the second BUSY cycle
    req = 2'b01; wr = 2'b00; addr[0 +: XLEN] = 32'h100; size[0 +: 3] = 3'd2;
    step();
    check("t1_bus_en", 32'(bus_en_rr), 32'd1);
    check("t1_addr", addr_rr, 32'h100);
    check("t1_wr_rd", 32'(wr_rd_rr), 32'd0);
    check("t1_size", 32'(size_rr), 32'd2);
    check("t1_state", 32'(state_rr), 32'd1);
    step();
    check("t1_bus_en_hold", 32'(bus_en_rr), 32'd1);
    check("t1_ready_early", 32'(ready_rr), 32'd0);
    ack = 1'b1; rd_data = 32'hDEAD_BEEF;
    step();
    check("t1_ready", 32'(ready_rr), 32'd1);
    check("t1_err", 32'(err_rr), 32'd0);
    check("t1_rdata", rdata_rr, 32'hDEAD_BEEF);
    check("t1_bus_en_off", 32'(bus_en_rr), 32'd0);
    check("t1_state_resp", 32'(state_rr), 32'd2);
    req = 2'b00; ack = 1'b0;
    step();
    check("t1_ready_pulse", 32'(ready_rr), 32'd0);

    // T2: write from master 1; master 0 payload must not leak onto the bus
    req = 2'b10; wr = 2'b10;
    addr[XLEN +: XLEN] = 32'h200; wdata[XLEN +: XLEN] = 32'h1234_5678; size[3 +: 3] = 3'd2;
    addr[0 +: XLEN] = 32'hBAD0; wdata[0 +: XLEN] = 32'hBAD1; size[0 +: 3] = 3'd1;
    step();
    check("t2_bus_en", 32'(bus_en_rr), 32'd1);
    check("t2_wr_rd", 32'(wr_rd_rr), 32'd1);
    check("t2_addr", addr_rr, 32'h200);
    check("t2_wr_data", wr_data_rr, 32'h1234_5678);
    check("t2_size", 32'(size_rr), 32'd2);
    ack = 1'b1; rd_data = 32'hAAAA_5555;
    step();
    check("t2_ready", 32'(ready_rr), 32'd2);
    check("t2_rdata_write", rdata_rr, 32'd0);
    req = 2'b00; wr = 2'b00; ack = 1'b0;
    step();

    // T3: both masters request continuously
    addr[0 +: XLEN] = 32'h1000; addr[XLEN +: XLEN] = 32'h2000;
    req = 2'b11;
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    for (int t = 0; t < 4; t++) begin
      step();
      g = exp_q.pop_front();
      check("t3_rr_addr", addr_rr, (g == 1'b1) ? 32'h2000 : 32'h1000);
      check("t3_fx_addr", addr_fx, 32'h1000);
      ack = 1'b1; rd_data = 32'h5A5A_0000 + 32'(t);
      step();
      check("t3_rr_ready", 32'(ready_rr), 32'(2'b01 << g));
      check("t3_fx_ready", 32'(ready_fx), 32'd1);
      check("t3_rr_rdata", rdata_rr, 32'h5A5A_0000 + 32'(t));
      ack = 1'b0;
      step();
    end
    req = 2'b10;
    step();
    check("t3_fx_m1", addr_fx, 32'h2000);
    check("t3_rr_m1", addr_rr, 32'h2000);
    ack = 1'b1; rd_data = 32'h77;
    step();
    check("t3_fx_ready_m1", 32'(ready_fx), 32'd2);
    req = 2'b00; ack = 1'b0;
    step();

    // T4: no acknowledge; abort after four BUSY cycles
    req = 2'b01; addr[0 +: XLEN] = 32'h300;
    for (int c = 1; c <= 4; c++) begin
      step();
      check("t4_bus_en", 32'(bus_en_rr), 32'd1);
      check("t4_no_ready", 32'(ready_rr), 32'd0);
    end
    step();
    check("t4_ready", 32'(ready_rr), 32'd1);
    check("t4_err", 32'(err_rr), 32'd1);
    check("t4_rdata", rdata_rr, 32'd0);
    check("t4_bus_en_off", 32'(bus_en_rr), 32'd0);
    check("t4_fx_err", 32'(err_fx), 32'd1);
    req = 2'b00;
    step();
    check("t4_err_pulse", 32'(err_rr), 32'd0);

    // T5: reset during BUSY, then master 0 must win first
    req = 2'b01; addr[0 +: XLEN] = 32'h400;
    step();
    check("t5_bus_en", 32'(bus_en_rr), 32'd1);
    check("t5_addr", addr_rr, 32'h400);
    rst = 1'b1;
    step();
    check("t5_rst_bus_en", 32'(bus_en_rr), 32'd0);
    check("t5_rst_ready", 32'(ready_rr), 32'd0);
    check("t5_rst_err", 32'(err_rr), 32'd0);
    check("t5_rst_state", 32'(state_rr), 32'd0);
    rst = 1'b0; req = 2'b11; addr[XLEN +: XLEN] = 32'h500;
    step();
    check("t5_first_grant", addr_rr, 32'h400);
    check("t5_no_ready", 32'(ready_rr), 32'd0);
    ack = 1'b1; rd_data = 32'h0BAD_F00D;
    step();
    check("t5_ready", 32'(ready_rr), 32'd1);
    req = 2'b00; ack = 1'b0;
    step();
    check("t5_idle", 32'(state_rr), 32'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
